id_queue: RTL

//  Buffered RV32I decode stage between instruction fetch and dispatch. Queues fetched
//  {instr, pc} pairs in a DEPTH-entry FIFO and decodes the head entry into a registered

---
 rtl/id_queue.sv | 341 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_queue.sv
//==============================================================================
// Module   : id_queue
// Summary  : Buffered RV32I decode stage. A DEPTH-entry FIFO holds fetched
//            {instr, pc} pairs. The head entry is decoded and registered into
//            a single output slot, with valid/ready handshakes on both sides.
//            flush_in drops all queued and slotted work.
// Options  : ID_RV32M_EN - decode the RV32M multiply/divide group
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef ID_QUEUE_CONFIG_VH
`define ID_QUEUE_CONFIG_VH
`define InstrWidth   32
`define AddrWidth    32
`define InstrIdWidth 6
`define RegIdxWidth  5
`define ZERO   6'd0
`define LUI    6'd1
`define AUIPC  6'd2
`define JAL    6'd3
`define JALR   6'd4
`define BEQ    6'd5
`define BNE    6'd6
`define BLT    6'd7
`define BGE    6'd8
`define BLTU   6'd9
`define BGEU   6'd10
`define LB     6'd11
`define LH     6'd12
`define LW     6'd13
`define LBU    6'd14
`define LHU    6'd15
`define SB     6'd16
`define SH     6'd17
`define SW     6'd18
`define ADDI   6'd19
`define SLTI   6'd20
`define SLTIU  6'd21
`define XORI   6'd22
`define ORI    6'd23
`define ANDI   6'd24
`define SLLI   6'd25
`define SRLI   6'd26
`define SRAI   6'd27
`define ADD    6'd28
`define SUB    6'd29
`define SLL    6'd30
`define SLT    6'd31
`define SLTU   6'd32
`define XOR    6'd33
`define SRL    6'd34
`define SRA    6'd35
`define OR     6'd36
`define AND    6'd37
`define MUL    6'd38
`define MULH   6'd39
`define MULHSU 6'd40
`define MULHU  6'd41
`define DIV    6'd42
`define DIVU   6'd43
`define REM    6'd44
`define REMU   6'd45
`endif

module id_queue #(
  parameter int DEPTH     = 4,
  parameter int IMM_WIDTH = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      flush_in,
  input  logic                      if_valid_in,
  output logic                      if_ready_out,
  input  logic [`InstrWidth-1:0]    instr_in,
  input  logic [`AddrWidth-1:0]     pc_in,
  output logic                      id_valid_out,
  input  logic                      dispatch_ready_in,
  output logic [`InstrIdWidth-1:0]  instr_id_out,
  output logic [IMM_WIDTH-1:0]      imm_out,
  output logic [`RegIdxWidth-1:0]   rs1_out,
  output logic [`RegIdxWidth-1:0]   rs2_out,
  output logic [`RegIdxWidth-1:0]   rd_out,
  output logic [`AddrWidth-1:0]     pc_out,
  output logic                      illegal_out
);

  localparam int             c_ptr_w = $clog2(DEPTH);
  localparam int             c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  logic [`InstrWidth-1:0]   r_mem_instr [DEPTH];
  logic [`AddrWidth-1:0]    r_mem_pc    [DEPTH];
  logic [c_ptr_w-1:0]       r_head, r_tail;
  logic [c_cnt_w-1:0]       r_count;
  logic                     r_valid;
  logic [`InstrIdWidth-1:0] r_id;
  logic [IMM_WIDTH-1:0]     r_imm;
  logic [`RegIdxWidth-1:0]  r_rs1, r_rs2, r_rd;
  logic [`AddrWidth-1:0]    r_pc;
  logic                     r_illegal;

  logic                     w_enq, w_deq;
  logic [`InstrWidth-1:0]   w_instr;
  logic [2:0]               w_f3;
  logic [6:0]               w_f7;
  logic [`InstrIdWidth-1:0] w_id;
  logic [31:0]              w_imm32;
  logic [IMM_WIDTH-1:0]     w_imm;
  logic [`RegIdxWidth-1:0]  w_rs1, w_rs2, w_rd;
  logic                     w_bad;

  // Ready depends only on the registered count: a same-cycle dequeue gives no credit.
  assign if_ready_out = (r_count != c_full);
  assign w_enq = if_valid_in & if_ready_out & ~flush_in;
  assign w_deq = (r_count != '0) & (~r_valid | dispatch_ready_in) & ~flush_in;

  assign w_instr = r_mem_instr[r_head];
  assign w_f3    = w_instr[14:12];
  assign w_f7    = w_instr[31:25];

  // FIFO storage write; contents are don't-care until counted in.
  always_ff @(posedge clk_in) begin
    if (w_enq) begin
      r_mem_instr[r_tail] <= instr_in;
      r_mem_pc[r_tail]    <= pc_in;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + c_ptr_w'(1);
      if (w_deq) r_head <= r_head + c_ptr_w'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Decode of the FIFO head entry; illegal encodings collapse to ZERO with imm 0.
  always_comb begin
    w_id    = `ZERO;
    w_imm32 = '0;
    w_rs1   = '0;
    w_rs2   = '0;
    w_rd    = '0;
    w_bad   = 1'b0;
    if (w_instr[1:0] != 2'b11) begin
      w_bad = 1'b1;
    end else begin
      case (w_instr[6:0])
        7'b0110111, 7'b0010111: begin
          w_id    = (w_instr[5]) ? `LUI : `AUIPC;
          w_imm32 = {w_instr[31:12], 12'b0};
          w_rd    = w_instr[11:7];
        end
        7'b1101111: begin
          w_id    = `JAL;
          w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
          w_rd    = w_instr[11:7];
        end
        7'b1100111: begin
          w_id    = `JALR;
          w_bad   = (w_f3 != 3'b000);
          w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
          w_rs1   = w_instr[19:15];
          w_rd    = w_instr[11:7];
        end
        7'b1100011: begin
          w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
          w_rs1   = w_instr[19:15];
          w_rs2   = w_instr[24:20];
          case (w_f3)
            3'b000:  w_id = `BEQ;
            3'b001:  w_id = `BNE;
            3'b100:  w_id = `BLT;
            3'b101:  w_id = `BGE;
            3'b110:  w_id = `BLTU;
            3'b111:  w_id = `BGEU;
            default: w_bad = 1'b1;
          endcase
        end
        7'b0000011: begin
          w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
          w_rs1   = w_instr[19:15];
          w_rd    = w_instr[11:7];
          case (w_f3)
            3'b000:  w_id = `LB;
            3'b001:  w_id = `LH;
            3'b010:  w_id = `LW;
            3'b100:  w_id = `LBU;
            3'b101:  w_id = `LHU;
            default: w_bad = 1'b1;
          endcase
        end
        7'b0100011: begin
          w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
          w_rs1   = w_instr[19:15];
          w_rs2   = w_instr[24:20];
          case (w_f3)
            3'b000:  w_id = `SB;
            3'b001:  w_id = `SH;
            3'b010:  w_id = `SW;
            default: w_bad = 1'b1;
          endcase
        end
        7'b0010011: begin
          w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
          w_rs1   = w_instr[19:15];
          w_rd    = w_instr[11:7];
          case (w_f3)
            3'b000: w_id = `ADDI;
            3'b010: w_id = `SLTI;
            3'b011: w_id = `SLTIU;
            3'b100: w_id = `XORI;
            3'b110: w_id = `ORI;
            3'b111: w_id = `ANDI;
            3'b001: begin
              // Shift amount is zero-extended; instr[25] set would be a 64-bit shamt.
              w_imm32 = {27'b0, w_instr[24:20]};
              w_id    = `SLLI;
              w_bad   = (w_f7 != 7'b0000000);
            end
            3'b101: begin
              w_imm32 = {27'b0, w_instr[24:20]};
              if (w_f7 == 7'b0000000)      w_id  = `SRLI;
              else if (w_f7 == 7'b0100000) w_id  = `SRAI;
              else                         w_bad = 1'b1;
            end
          endcase
        end
        7'b0110011: begin
          w_rs1 = w_instr[19:15];
          w_rs2 = w_instr[24:20];
          w_rd  = w_instr[11:7];
          case (w_f7)
            7'b0000000: begin
              case (w_f3)
                3'b000: w_id = `ADD;
                3'b001: w_id = `SLL;
                3'b010: w_id = `SLT;
                3'b011: w_id = `SLTU;
                3'b100: w_id = `XOR;
                3'b101: w_id = `SRL;
                3'b110: w_id = `OR;
                3'b111: w_id = `AND;
              endcase
            end
            7'b0100000: begin
              if (w_f3 == 3'b000)      w_id  = `SUB;
              else if (w_f3 == 3'b101) w_id  = `SRA;
              else                     w_bad = 1'b1;
            end
`ifdef ID_RV32M_EN
            7'b0000001: begin
              case (w_f3)
                3'b000: w_id = `MUL;
                3'b001: w_id = `MULH;
                3'b010: w_id = `MULHSU;
                3'b011: w_id = `MULHU;
                3'b100: w_id = `DIV;
                3'b101: w_id = `DIVU;
                3'b110: w_id = `REM;
                3'b111: w_id = `REMU;
              endcase
            end
`endif
            default: w_bad = 1'b1;
          endcase
        end
        default: w_bad = 1'b1;
      endcase
    end
    if (w_bad) begin
      w_id    = `ZERO;
      w_imm32 = '0;
      w_rs1   = '0;
      w_rs2   = '0;
      w_rd    = '0;
    end
  end

  // Fit the 32-bit immediate to IMM_WIDTH, sign-extending when wider.
  generate
    if (IMM_WIDTH > 32) begin : g_imm_wide
      assign w_imm = {{(IMM_WIDTH-32){w_imm32[31]}}, w_imm32};
    end else begin : g_imm_narrow
      assign w_imm = w_imm32[IMM_WIDTH-1:0];
    end
  endgenerate

  // Output slot: loads the decoded head, holds under backpressure, empties on consume.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_imm     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_pc      <= '0;
      r_illegal <= 1'b0;
    end else if (flush_in) begin
      r_valid <= 1'b0;
    end else if (w_deq) begin
      r_valid   <= 1'b1;
      r_id      <= w_id;
      r_imm     <= w_imm;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_rd      <= w_rd;
      r_pc      <= r_mem_pc[r_head];
      r_illegal <= w_bad;
    end else if (dispatch_ready_in) begin
      r_valid <= 1'b0;
    end
  end

  assign id_valid_out = r_valid;
  assign instr_id_out = r_id;
  assign imm_out      = r_imm;
  assign rs1_out      = r_rs1;
  assign rs2_out      = r_rs2;
  assign rd_out       = r_rd;
  assign pc_out       = r_pc;
  assign illegal_out  = r_illegal;

endmodule

`default_nettype wire
